adder_share_sched: RTL and testbench

- Sequencer/arbiter that shares one 4-bit ripple adder and one seven-segment decoder between two operand requesters.
- Grants requesters round-robin and drives the chosen operands onto the shared adder.
- Captures sum and carry, then steps the display through sum (DWELL cycles) and carry (DWELL cycles) before accepting the next request.
- Sits between the switch/operand sources and the existing four_bit_adder and seven_seg instances at the top level.

---
 rtl/adder_share_sched.sv | 149 ++++++++++++++
 tb/tb_adder_share_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_sched.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module  : adder_share_sched
// Purpose : Round-robin sequencer sharing one 4-bit adder and one
//           seven-segment decoder between two operand requesters. A grant
//           drives the winner's operands to the adder. The result is captured
//           and shown as the sum for DWELL cycles, then as the carry for
//           DWELL cycles.
// Ports   : clk, rst_n (sync, active-low)
//           req0/a0/b0/cin0, req1/a1/b1/cin1 : requester inputs
//           gnt0/gnt1                        : one-cycle grant pulses
//           add_a/add_b/add_cin -> adder, add_sum/add_cout <- adder
//           disp_val/disp_sel/disp_src       : display value, phase, source
//           busy                             : high outside IDLE
// Options : SKIP_ZERO_COUT_EN - skip the carry phase when the carry is 0
// Rev     : 1.0 - initial release
//-----------------------------------------------------------------------------
module adder_share_sched #(
   parameter int DWELL = 50000000,
   parameter int CW    = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic       cin0,
   input  logic       req1,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   input  logic       cin1,
   output logic       gnt0,
   output logic       gnt1,
   output logic [3:0] add_a,
   output logic [3:0] add_b,
   output logic       add_cin,
   input  logic [3:0] add_sum,
   input  logic       add_cout,
   output logic [3:0] disp_val,
   output logic       disp_sel,
   output logic       disp_src,
   output logic       busy
);

   localparam logic [1:0] c_IDLE      = 2'd0;
   localparam logic [1:0] c_ISSUE     = 2'd1;
   localparam logic [1:0] c_SHOW_SUM  = 2'd2;
   localparam logic [1:0] c_SHOW_COUT = 2'd3;

   localparam logic [CW-1:0] c_DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] c_CNT_ONE    = CW'(1);

   logic [1:0]    r_state;
   logic          r_last;
   logic          r_gnt0;
   logic          r_gnt1;
   logic [3:0]    r_add_a;
   logic [3:0]    r_add_b;
   logic          r_add_cin;
   logic [3:0]    r_res_sum;
   logic          r_res_cout;
   logic          r_src;
   logic [CW-1:0] r_cnt;

   logic w_pick;
   logic w_any_req;
   logic w_cnt_done;

   // Under contention the requester that was not served last wins;
   // otherwise the single active requester is taken.
   assign w_any_req  = req0 | req1;
   assign w_pick     = (req0 & req1) ? ~r_last : req1;
   assign w_cnt_done = (r_cnt == c_DWELL_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= c_IDLE;
         r_last     <= 1'b1;
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
         r_add_a    <= 4'd0;
         r_add_b    <= 4'd0;
         r_add_cin  <= 1'b0;
         r_res_sum  <= 4'd0;
         r_res_cout <= 1'b0;
         r_src      <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_gnt0 <= 1'b0;
         r_gnt1 <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_any_req) begin
                  r_state   <= c_ISSUE;
                  r_last    <= w_pick;
                  r_src     <= w_pick;
                  r_gnt0    <= ~w_pick;
                  r_gnt1    <= w_pick;
                  r_add_a   <= w_pick ? a1   : a0;
                  r_add_b   <= w_pick ? b1   : b0;
                  r_add_cin <= w_pick ? cin1 : cin0;
               end
            end
            c_ISSUE: begin
               // Operands have been stable for a full cycle; the adder
               // output is settled at this closing edge.
               r_res_sum  <= add_sum;
               r_res_cout <= add_cout;
               r_cnt      <= '0;
               r_state    <= c_SHOW_SUM;
            end
            c_SHOW_SUM: begin
               if (w_cnt_done) begin
                  r_cnt <= '0;
`ifdef SKIP_ZERO_COUT_EN
                  r_state <= r_res_cout ? c_SHOW_COUT : c_IDLE;
`else
                  r_state <= c_SHOW_COUT;
`endif
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            c_SHOW_COUT: begin
               if (w_cnt_done) begin
                  r_cnt   <= '0;
                  r_state <= c_IDLE;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign gnt0     = r_gnt0;
   assign gnt1     = r_gnt1;
   assign add_a    = r_add_a;
   assign add_b    = r_add_b;
   assign add_cin  = r_add_cin;
   assign disp_src = r_src;
   assign busy     = (r_state != c_IDLE);
   // The last sum stays on the display while idle.
   assign disp_sel = (r_state == c_SHOW_COUT);
   assign disp_val = disp_sel ? {3'b000, r_res_cout} : r_res_sum;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_sched.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module  : tb_adder_share_sched
// Purpose : Self-checking bench for adder_share_sched with DWELL=4, CW=3.
//           Directed vector table plus hand-written sequences for
//           alternation and mid-operation reset.
// Options : SKIP_ZERO_COUT_EN - carry-phase expectations follow the macro
// Rev     : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_adder_share_sched;

   localparam int DWELL = 4;
   localparam int CW    = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, cin0, cin1;
   logic [3:0] a0, b0, a1, b1;
   logic       gnt0, gnt1;
   logic [3:0] add_a, add_b, add_sum, disp_val;
   logic       add_cin, add_cout, disp_sel, disp_src, busy;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       r0;
      logic [3:0] a0;
      logic [3:0] b0;
      logic       c0;
      logic       r1;
      logic [3:0] a1;
      logic [3:0] b1;
      logic       c1;
      logic       src;
      logic [3:0] sum;
      logic       cout;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   // Stand-in for the shared four_bit_adder instance.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

   adder_share_sched #(.DWELL(DWELL), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
      .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
      .gnt0(gnt0), .gnt1(gnt1),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .disp_val(disp_val), .disp_sel(disp_sel), .disp_src(disp_src),
      .busy(busy)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      bit ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk({nm, " wait_idle"}, int'(ok), 1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string t;
      bit    show_c;
      t = $sformatf("vec%0d", idx);
      req0 = v.r0; a0 = v.a0; b0 = v.b0; cin0 = v.c0;
      req1 = v.r1; a1 = v.a1; b1 = v.b1; cin1 = v.c1;
      tick();
      chk({t, " gnt0"}, int'(gnt0), int'(!v.src));
      chk({t, " gnt1"}, int'(gnt1), int'(v.src));
      chk({t, " add_a"}, int'(add_a), int'(v.src ? v.a1 : v.a0));
      chk({t, " add_b"}, int'(add_b), int'(v.src ? v.b1 : v.b0));
      chk({t, " add_cin"}, int'(add_cin), int'(v.src ? v.c1 : v.c0));
      chk({t, " busy_issue"}, int'(busy), 1);
      req0 = 1'b0;
      req1 = 1'b0;
      for (int i = 0; i < DWELL; i++) begin
         tick();
         chk({t, " sum_val"}, int'(disp_val), int'(v.sum));
         chk({t, " sum_sel"}, int'(disp_sel), 0);
         chk({t, " sum_gnt"}, int'(gnt0 | gnt1), 0);
      end
      chk({t, " disp_src"}, int'(disp_src), int'(v.src));
`ifdef SKIP_ZERO_COUT_EN
      show_c = v.cout;
`else
      show_c = 1'b1;
`endif
      if (show_c) begin
         for (int i = 0; i < DWELL; i++) begin
            tick();
            chk({t, " cout_val"}, int'(disp_val), int'(v.cout));
            chk({t, " cout_sel"}, int'(disp_sel), 1);
            chk({t, " cout_busy"}, int'(busy), 1);
         end
      end
      tick();
      chk({t, " idle_busy"}, int'(busy), 0);
      chk({t, " idle_val"}, int'(disp_val), int'(v.sum));
      chk({t, " idle_sel"}, int'(disp_sel), 0);
      chk({t, " add_a_hold"}, int'(add_a), int'(v.src ? v.a1 : v.a0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int gt[4];
      int gi[4];
      int ng;
      int exp_t[4];
      int exp_i[4];

      //                 r0    a0     b0     c0    r1    a1     b1     c1    src   sum    cout
      tbl[0] = '{1'b1, 4'd3,  4'd4,  1'b1, 1'b1, 4'd15, 4'd1,  1'b0, 1'b0, 4'd8,  1'b0};
      tbl[1] = '{1'b1, 4'd9,  4'd8,  1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd1,  1'b1};
      tbl[2] = '{1'b1, 4'd1,  4'd1,  1'b0, 1'b1, 4'd15, 4'd1,  1'b0, 1'b1, 4'd0,  1'b1};
      tbl[3] = '{1'b1, 4'd15, 4'd15, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 4'd15, 1'b1};
      tbl[4] = '{1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 4'd7,  4'd8,  1'b1, 1'b1, 4'd0,  1'b1};
      tbl[5] = '{1'b1, 4'd2,  4'd2,  1'b0, 1'b1, 4'd3,  4'd3,  1'b1, 1'b0, 4'd4,  1'b0};

      // Reset with every input high.
      rst_n = 1'b0;
      req0 = 1'b1; a0 = 4'hF; b0 = 4'hF; cin0 = 1'b1;
      req1 = 1'b1; a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1;
      tick();
      tick();
      chk("rst gnt0", int'(gnt0), 0);
      chk("rst gnt1", int'(gnt1), 0);
      chk("rst add_a", int'(add_a), 0);
      chk("rst add_b", int'(add_b), 0);
      chk("rst add_cin", int'(add_cin), 0);
      chk("rst disp_val", int'(disp_val), 0);
      chk("rst disp_sel", int'(disp_sel), 0);
      chk("rst disp_src", int'(disp_src), 0);
      chk("rst busy", int'(busy), 0);
      rst_n = 1'b1;

      for (int k = 0; k < 6; k++) run_vec(tbl[k], k);

      // Both requesters held: grants alternate, starting with 1 (last was 0).
      req0 = 1'b1; a0 = 4'd3;  b0 = 4'd4; cin0 = 1'b1;
      req1 = 1'b1; a1 = 4'd15; b1 = 4'd1; cin1 = 1'b0;
      exp_t[0] = 0;
      exp_t[1] = 10;
`ifdef SKIP_ZERO_COUT_EN
      exp_t[2] = 16;
`else
      exp_t[2] = 20;
`endif
      exp_t[3] = exp_t[2] + 10;
      exp_i = '{1, 0, 1, 0};
      ng = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (gnt0 && gnt1) chk("alt both_gnt", 1, 0);
         if ((gnt0 || gnt1) && ng < 4) begin
            gt[ng] = k;
            gi[ng] = gnt1 ? 1 : 0;
            ng++;
         end
         if (k == 1) begin
            chk("alt r1 sum", int'(disp_val), 0);
            chk("alt r1 src", int'(disp_src), 1);
         end
         if (k == 5) begin
            chk("alt r1 cout", int'(disp_val), 1);
            chk("alt r1 sel", int'(disp_sel), 1);
         end
      end
      chk("alt grant_count", ng, 4);
      for (int i = 0; i < 4; i++) begin
         if (i < ng) begin
            chk($sformatf("alt grant%0d idx", i), gi[i], exp_i[i]);
            chk($sformatf("alt grant%0d time", i), gt[i], exp_t[i]);
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      wait_idle("alt");
      tick();

      // Reset during SHOW_SUM with req1 pending.
      req0 = 1'b1; a0 = 4'd5; b0 = 4'd6; cin0 = 1'b0;
      tick();
      chk("mrst gnt0", int'(gnt0), 1);
      req0 = 1'b0;
      req1 = 1'b1; a1 = 4'd1; b1 = 4'd2; cin1 = 1'b0;
      tick();
      chk("mrst sum", int'(disp_val), 11);
      rst_n = 1'b0;
      tick();
      chk("mrst busy", int'(busy), 0);
      chk("mrst disp_val", int'(disp_val), 0);
      chk("mrst gnt", int'(gnt0 | gnt1), 0);
      chk("mrst add_a", int'(add_a), 0);
      tick();
      chk("mrst hold gnt", int'(gnt0 | gnt1), 0);
      rst_n = 1'b1;
      tick();
      chk("mrst post gnt1", int'(gnt1), 1);
      chk("mrst post gnt0", int'(gnt0), 0);
      chk("mrst post add_a", int'(add_a), 1);
      req1 = 1'b0;
      tick();
      tick();
      // Second abort; with both pending, requester 0 wins after release.
      rst_n = 1'b0;
      req0 = 1'b1;
      req1 = 1'b1;
      tick();
      chk("mrst2 busy", int'(busy), 0);
      rst_n = 1'b1;
      tick();
      chk("mrst2 gnt0", int'(gnt0), 1);
      chk("mrst2 gnt1", int'(gnt1), 0);
      req0 = 1'b0;
      req1 = 1'b0;
      wait_idle("mrst2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
